// File: rtl/button_event_gen_pkg.sv
// Shared types and default timing for the button event generator.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } btn_state_t;

  localparam int unsigned BTN_CNT_W_DEF           = 16;
  localparam int unsigned BTN_LONG_MS_DEF         = 1000;
  localparam int unsigned BTN_REPEAT_DELAY_MS_DEF = 500;
  localparam int unsigned BTN_REPEAT_RATE_MS_DEF  = 100;

endpackage

// File: rtl/button_event_gen_if.sv
// Debounced level in, UI events and hold duration out.
interface button_event_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             debounced_in;
  logic             press_pulse;
  logic             release_pulse;
  logic             long_press_pulse;
  logic             repeat_pulse;
  logic             held;
  logic [CNT_W-1:0] hold_ms;

  modport master (
    output debounced_in,
    input  press_pulse, release_pulse, long_press_pulse, repeat_pulse, held, hold_ms
  );

  modport slave (
    input  debounced_in,
    output press_pulse, release_pulse, long_press_pulse, repeat_pulse, held, hold_ms
  );
endinterface

// File: rtl/button_event_gen_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced switch level into press/release/long/repeat pulses
// and a saturating hold-duration count, one cycle per ms.
module button_event_gen
  import btn_evt_pkg::*;
#(
  parameter int unsigned CNT_W           = BTN_CNT_W_DEF,
  parameter int unsigned LONG_MS         = BTN_LONG_MS_DEF,
  parameter int unsigned REPEAT_DELAY_MS = BTN_REPEAT_DELAY_MS_DEF,
  parameter int unsigned REPEAT_RATE_MS  = BTN_REPEAT_RATE_MS_DEF,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic               clk_1KHz,
  input  logic               reset_n,
  button_event_gen_if.slave  bus
);

  localparam int unsigned XW = CNT_W + 1;

  btn_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             active;
  logic             long_hit;
  logic             rep_hit;

  // Counters run only while held and still pressed; press and release both clear them.
  assign active = (state != IDLE) && bus.debounced_in;

  // Extra bit keeps a saturated count from ever matching LONG_MS again.
  assign long_hit = active && (({1'b0, hold_cnt} + XW'(1)) == XW'(LONG_MS));

  assign rep_hit = REPEAT_EN && active &&
                   (((state == HELD)   && (({1'b0, rep_cnt} + XW'(1)) == XW'(REPEAT_DELAY_MS))) ||
                    ((state == REPEAT) && (({1'b0, rep_cnt} + XW'(1)) == XW'(REPEAT_RATE_MS))));

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk_1KHz),
    .rst_n (reset_n),
    .clr   (!active),
    .en    (active),
    .cnt   (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rep_cnt (
    .clk   (clk_1KHz),
    .rst_n (reset_n),
    .clr   (!active || rep_hit),
    .en    (active),
    .cnt   (rep_cnt)
  );

  assign bus.hold_ms = hold_cnt;

  always_ff @(posedge clk_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      bus.press_pulse      <= 1'b0;
      bus.release_pulse    <= 1'b0;
      bus.long_press_pulse <= 1'b0;
      bus.repeat_pulse     <= 1'b0;
      bus.held             <= 1'b0;
    end else begin
      bus.press_pulse      <= 1'b0;
      bus.release_pulse    <= 1'b0;
      bus.long_press_pulse <= 1'b0;
      bus.repeat_pulse     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.debounced_in) begin
            state           <= HELD;
            bus.press_pulse <= 1'b1;
            bus.held        <= 1'b1;
          end
        end
        HELD, REPEAT: begin
          if (!bus.debounced_in) begin
            state             <= IDLE;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else begin
            bus.long_press_pulse <= long_hit;
            bus.repeat_pulse     <= rep_hit;
            if (rep_hit) begin
              state <= REPEAT;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: cycle model of the event rules plus literal checks.
module tb_button_event_gen;

  localparam int LONG = 8;
  localparam int DLY  = 4;
  localparam int RATE = 2;
  localparam int HMAX = 15;

  typedef struct packed {
    logic       press;
    logic       rel;
    logic       lng;
    logic       rep;
    logic       held;
    logic [3:0] hold;
  } obs_t;

  typedef struct packed {
    logic        pressed;
    logic [31:0] k;
    obs_t        o;
  } mstate_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_gen_if #(.CNT_W(4)) if_a ();
  button_event_gen_if #(.CNT_W(4)) if_b ();

  assign if_a.debounced_in = din;
  assign if_b.debounced_in = din;

  button_event_gen #(
    .CNT_W(4), .LONG_MS(LONG), .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk_1KHz (clk),
    .reset_n  (reset_n),
    .bus      (if_a.slave)
  );

  button_event_gen #(
    .CNT_W(4), .LONG_MS(LONG), .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE), .REPEAT_EN(1'b0)
  ) dut_b (
    .clk_1KHz (clk),
    .reset_n  (reset_n),
    .bus      (if_b.slave)
  );

  // Event rules in terms of k = cycles since the press cycle.
  function automatic mstate_t step(mstate_t s, logic in, bit en);
    mstate_t n;
    int k;
    n = '0;
    n.pressed = s.pressed;
    n.k = s.k;
    if (!s.pressed) begin
      if (in) begin
        n.pressed = 1'b1;
        n.k = 0;
        n.o.press = 1'b1;
        n.o.held = 1'b1;
      end
    end else if (in) begin
      k = int'(s.k) + 1;
      n.k = 32'(k);
      n.o.held = 1'b1;
      n.o.hold = (k > HMAX) ? 4'(HMAX) : 4'(k);
      n.o.lng = (k == LONG);
      n.o.rep = en && (k >= DLY) && (((k - DLY) % RATE) == 0);
    end else begin
      n.pressed = 1'b0;
      n.o.rel = 1'b1;
    end
    return n;
  endfunction

  mstate_t ms_a, ms_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_a <= '0;
      ms_b <= '0;
    end else begin
      ms_a <= step(ms_a, din, 1'b1);
      ms_b <= step(ms_b, din, 1'b0);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got press/rel/long/rep/held=%b%b%b%b%b hold=%0d exp %b%b%b%b%b hold=%0d at %0t",
               name, got.press, got.rel, got.lng, got.rep, got.held, got.hold,
               exp.press, exp.rel, exp.lng, exp.rep, exp.held, exp.hold, $time);
    end
  endtask

  function automatic obs_t obs_a();
    return {if_a.press_pulse, if_a.release_pulse, if_a.long_press_pulse,
            if_a.repeat_pulse, if_a.held, if_a.hold_ms};
  endfunction

  function automatic obs_t obs_b();
    return {if_b.press_pulse, if_b.release_pulse, if_b.long_press_pulse,
            if_b.repeat_pulse, if_b.held, if_b.hold_ms};
  endfunction

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nlong;
    fork
      forever begin
        @(negedge clk);
        cmp("model_a", obs_a(), ms_a.o);
        cmp("model_b", obs_b(), ms_b.o);
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_held", int'(if_a.held), 0);
    chk("rst_hold", int'(if_a.hold_ms), 0);
    chk("rst_press", int'(if_a.press_pulse), 0);
    reset_n = 1'b1;
    idle(2);

    // Hold 10 samples then drop
    din = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_hold", int'(if_a.hold_ms), i);
      if (i == 0) chk("t1_press", int'(if_a.press_pulse), 1);
      if (i == 4) chk("t1_rep4", int'(if_a.repeat_pulse), 1);
      if (i == 4) chk("t1_b_norep", int'(if_b.repeat_pulse), 0);
      if (i == 8) chk("t1_long8", int'(if_a.long_press_pulse), 1);
      if (i == 8) chk("t1_rep8", int'(if_a.repeat_pulse), 1);
      if (i == 8) chk("t1_b_long8", int'(if_b.long_press_pulse), 1);
    end
    din = 1'b0;
    @(negedge clk);
    chk("t1_release", int'(if_a.release_pulse), 1);
    chk("t1_held0", int'(if_a.held), 0);
    idle(3);

    // Hold 7 samples then drop: release lands where no long fires
    din = 1'b1;
    repeat (7) @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    chk("t2_release", int'(if_a.release_pulse), 1);
    chk("t2_hold0", int'(if_a.hold_ms), 0);
    chk("t2_nolong", int'(if_a.long_press_pulse), 0);
    idle(3);

    // Hold 20 samples: saturation, single long, continued repeats
    din = 1'b1;
    nlong = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_a.long_press_pulse) nlong++;
      if (i >= 15) chk("t3_sat", int'(if_a.hold_ms), HMAX);
      if (i == 18) chk("t3_rep18", int'(if_a.repeat_pulse), 1);
    end
    chk("t3_long_count", nlong, 1);
    idle(3);

    // Single-sample high, then immediate re-press
    din = 1'b1;
    @(negedge clk);
    chk("t4_press", int'(if_a.press_pulse), 1);
    din = 1'b0;
    @(negedge clk);
    chk("t4_release", int'(if_a.release_pulse), 1);
    chk("t4_nopress", int'(if_a.press_pulse), 0);
    din = 1'b1;
    @(negedge clk);
    chk("t4_repress", int'(if_a.press_pulse), 1);
    idle(3);

    // Reset mid-hold with input still high
    din = 1'b1;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_held", int'(if_a.held), 0);
    chk("t5_rst_hold", int'(if_a.hold_ms), 0);
    chk("t5_rst_rep", int'(if_a.repeat_pulse), 0);
    repeat (3) @(negedge clk);
    chk("t5_norel", int'(if_a.release_pulse), 0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("t5_press", int'(if_a.press_pulse), 1);
    chk("t5_hold0", int'(if_a.hold_ms), 0);
    @(negedge clk);
    chk("t5_hold1", int'(if_a.hold_ms), 1);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
